// File: rtl/hash_writeback.sv
// Hash vector write-back engine: captures a hash on start and streams it out
// one word per accepted write, starting at a base address, with ready backpressure.
module hash_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter bit MSW_FIRST  = 1'b0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] hash_vector,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic                            wr_ready,
  output logic                            wr_en,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic                            busy,
  output logic                            done
);
  localparam int CNT_W = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                               state_q, state_d;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] vec_q, vec_d;
  logic [ADDR_WIDTH-1:0]                base_q, base_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] words_in;
  logic                                 accept;
  logic                                 last;

  // Word order is resolved at capture so readout is a plain index by cnt.
  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    localparam int SRC = MSW_FIRST ? (NUM_WORDS - 1 - k) : k;
    assign words_in[k] = hash_vector[SRC*DATA_WIDTH +: DATA_WIDTH];
  end

  assign accept = (state_q == WRITE) && wr_ready;
  assign last   = (cnt_q == CNT_W'(NUM_WORDS - 1));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = words_in;
          base_d  = base_addr;
          cnt_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          if (last) state_d = DONE;
          else      cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state only; address wraps silently.
  assign wr_en   = (state_q == WRITE);
  assign wr_addr = wr_en ? (base_q + ADDR_WIDTH'(cnt_q)) : '0;
  assign wr_data = wr_en ? vec_q[cnt_q] : '0;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
endmodule

// File: tb/tb_hash_writeback.sv
// Bench for hash_writeback: three configurations checked each cycle against a
// word-list model, plus literal expectations on the logged write streams.
module tb_hash_writeback;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         st  [3];
  logic [255:0] hv  [3];
  logic [7:0]   ba  [3];
  logic         rdy [3];

  logic        en0, en1, en2, bz0, bz1, bz2, dn0, dn1, dn2;
  logic [7:0]  ad0, ad1;
  logic [3:0]  ad2;
  logic [31:0] da0, da1;
  logic [63:0] da2;

  hash_writeback d0 (.clock(clock), .reset(reset), .start(st[0]), .hash_vector(hv[0]),
    .base_addr(ba[0]), .wr_ready(rdy[0]), .wr_en(en0), .wr_addr(ad0), .wr_data(da0),
    .busy(bz0), .done(dn0));
  hash_writeback #(.MSW_FIRST(1'b1)) d1 (.clock(clock), .reset(reset), .start(st[1]),
    .hash_vector(hv[1]), .base_addr(ba[1]), .wr_ready(rdy[1]), .wr_en(en1), .wr_addr(ad1),
    .wr_data(da1), .busy(bz1), .done(dn1));
  hash_writeback #(.DATA_WIDTH(64), .NUM_WORDS(4), .ADDR_WIDTH(4)) d2 (.clock(clock),
    .reset(reset), .start(st[2]), .hash_vector(hv[2]), .base_addr(ba[2][3:0]),
    .wr_ready(rdy[2]), .wr_en(en2), .wr_addr(ad2), .wr_data(da2), .busy(bz2), .done(dn2));

  // Model: on capture, the full list of (addr, data) writes is laid out;
  // a pointer walks it as writes are accepted, then one done cycle follows.
  int          ecount = 0;
  bit          m_act  [3];
  bit          m_done [3];
  int          m_idx  [3];
  logic [7:0]  m_addr [3][8];
  logic [63:0] m_data [3][8];
  int          nw     [3] = '{8, 8, 4};

  always @(posedge clock) begin
    ecount++;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_act[i] = 0; m_done[i] = 0;
      end else if (m_done[i]) begin
        m_done[i] = 0;
      end else if (m_act[i]) begin
        if (rdy[i]) begin
          m_idx[i]++;
          if (m_idx[i] == nw[i]) begin m_act[i] = 0; m_done[i] = 1; end
        end
      end else if (st[i]) begin
        for (int k = 0; k < nw[i]; k++) begin
          int kk;
          kk = (i == 1) ? nw[i] - 1 - k : k;
          m_data[i][k] = (i == 2) ? hv[i][kk*64 +: 64] : {32'h0, hv[i][kk*32 +: 32]};
          m_addr[i][k] = 8'(ba[i] + 8'(k)) & ((i == 2) ? 8'h0F : 8'hFF);
        end
        m_act[i] = 1; m_idx[i] = 0;
      end
    end
  end

  int errs = 0, checks = 0;
  bit chk_en = 0;
  logic [7:0]  lg_addr [3][64];
  logic [63:0] lg_data [3][64];
  int          lg_cyc  [3][64];
  int          lg_n    [3] = '{0, 0, 0};
  int          dn_cyc  [3][16];
  int          dn_n    [3] = '{0, 0, 0};

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      logic e, b, d; logic [7:0] a; logic [63:0] x;
      case (i)
        0: begin e = en0; b = bz0; d = dn0; a = ad0; x = {32'h0, da0}; end
        1: begin e = en1; b = bz1; d = dn1; a = ad1; x = {32'h0, da1}; end
        default: begin e = en2; b = bz2; d = dn2; a = {4'h0, ad2}; x = da2; end
      endcase
      chk($sformatf("wr_en d%0d", i), 64'(e), 64'(m_act[i]));
      chk($sformatf("busy d%0d", i), 64'(b), 64'(m_act[i] || m_done[i]));
      chk($sformatf("done d%0d", i), 64'(d), 64'(m_done[i]));
      chk($sformatf("wr_addr d%0d", i), 64'(a), m_act[i] ? 64'(m_addr[i][m_idx[i]]) : 64'h0);
      chk($sformatf("wr_data d%0d", i), x, m_act[i] ? m_data[i][m_idx[i]] : 64'h0);
      if (e === 1'b1 && rdy[i] && lg_n[i] < 64) begin
        lg_addr[i][lg_n[i]] = a; lg_data[i][lg_n[i]] = x; lg_cyc[i][lg_n[i]] = ecount;
        lg_n[i]++;
      end
      if (d === 1'b1 && dn_n[i] < 16) begin dn_cyc[i][dn_n[i]] = ecount; dn_n[i]++; end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      if (chk_en) compare_all();
      @(posedge clock); #1;
    end
  endtask

  task automatic load_a(input int i);
    for (int k = 0; k < 8; k++) hv[i][k*32 +: 32] = 32'hA000_0000 + 32'(k);
  endtask

  int s, n0, n1, q0;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin st[i] = 0; hv[i] = '0; ba[i] = '0; rdy[i] = 1; end
    @(posedge clock); #1;
    chk_en = 1;
    tick();
    chk("reset wr_en", 64'(en0), 64'h0);
    chk("reset busy", 64'(bz0), 64'h0);
    chk("reset done", 64'(dn0), 64'h0);
    reset = 1'b0;

    // Basic transfer, both word orders
    load_a(0); load_a(1); ba[0] = 8'h10; ba[1] = 8'h10;
    n0 = lg_n[0]; n1 = lg_n[1]; q0 = dn_n[0];
    st[0] = 1; st[1] = 1; tick(); s = ecount; st[0] = 0; st[1] = 0;
    tick(12);
    chk("t1 count", 64'(lg_n[0] - n0), 64'd8);
    chk("t1 w0 addr", 64'(lg_addr[0][n0]), 64'h10);
    chk("t1 w0 data", lg_data[0][n0], 64'hA000_0000);
    chk("t1 w0 cycle", 64'(lg_cyc[0][n0] - s + 1), 64'd1);
    chk("t1 w7 addr", 64'(lg_addr[0][n0+7]), 64'h17);
    chk("t1 w7 data", lg_data[0][n0+7], 64'hA000_0007);
    chk("t1 w7 cycle", 64'(lg_cyc[0][n0+7] - s + 1), 64'd8);
    chk("t1 done count", 64'(dn_n[0] - q0), 64'd1);
    chk("t1 done cycle", 64'(dn_cyc[0][q0] - s + 1), 64'd9);
    chk("msw w0 addr", 64'(lg_addr[1][n1]), 64'h10);
    chk("msw w0 data", lg_data[1][n1], 64'hA000_0007);
    chk("msw w7 addr", 64'(lg_addr[1][n1+7]), 64'h17);
    chk("msw w7 data", lg_data[1][n1+7], 64'hA000_0000);

    // Backpressure: ready low for 3 cycles while word 2 is presented
    n0 = lg_n[0]; q0 = dn_n[0];
    st[0] = 1; tick(); s = ecount; st[0] = 0;
    tick(2);
    rdy[0] = 0; tick(3); rdy[0] = 1;
    tick(9);
    chk("bp count", 64'(lg_n[0] - n0), 64'd8);
    chk("bp w2 addr", 64'(lg_addr[0][n0+2]), 64'h12);
    chk("bp w2 data", lg_data[0][n0+2], 64'hA000_0002);
    chk("bp w2 cycle", 64'(lg_cyc[0][n0+2] - s + 1), 64'd6);
    chk("bp w3 data", lg_data[0][n0+3], 64'hA000_0003);
    chk("bp done cycle", 64'(dn_cyc[0][q0] - s + 1), 64'd12);

    // Address wrap, with a stray start mid-transfer
    n0 = lg_n[0]; q0 = dn_n[0]; ba[0] = 8'hFE;
    st[0] = 1; tick(); st[0] = 0;
    tick(2);
    hv[0] = {8{32'h5555_5555}}; ba[0] = 8'h40; st[0] = 1; tick(); st[0] = 0;
    tick(10);
    chk("wrap count", 64'(lg_n[0] - n0), 64'd8);
    chk("wrap w1 addr", 64'(lg_addr[0][n0+1]), 64'hFF);
    chk("wrap w2 addr", 64'(lg_addr[0][n0+2]), 64'h00);
    chk("wrap w7 addr", 64'(lg_addr[0][n0+7]), 64'h05);
    chk("wrap w7 data", lg_data[0][n0+7], 64'hA000_0007);
    chk("wrap done count", 64'(dn_n[0] - q0), 64'd1);
    load_a(0);

    // Reset while word 4 is presented
    n0 = lg_n[0]; q0 = dn_n[0]; ba[0] = 8'h10;
    st[0] = 1; tick(); st[0] = 0;
    tick(4);
    reset = 1; rdy[0] = 0; tick();
    chk("abort wr_en", 64'(en0), 64'h0);
    chk("abort busy", 64'(bz0), 64'h0);
    chk("abort done", 64'(dn0), 64'h0);
    reset = 0; rdy[0] = 1;
    tick(3);
    chk("abort count", 64'(lg_n[0] - n0), 64'd4);
    chk("abort no done", 64'(dn_n[0] - q0), 64'd0);
    n0 = lg_n[0]; q0 = dn_n[0];
    st[0] = 1; tick(); s = ecount; st[0] = 0;
    tick(10);
    chk("rerun count", 64'(lg_n[0] - n0), 64'd8);
    chk("rerun w0 addr", 64'(lg_addr[0][n0]), 64'h10);
    chk("rerun w0 data", lg_data[0][n0], 64'hA000_0000);
    chk("rerun done cycle", 64'(dn_cyc[0][q0] - s + 1), 64'd9);

    // 64-bit x 4 config, start held high: two back-to-back transfers
    n0 = lg_n[2]; q0 = dn_n[2]; ba[2] = 8'h03;
    for (int k = 0; k < 4; k++) hv[2][k*64 +: 64] = 64'hB000_0000_0000_0000 + 64'(k);
    st[2] = 1; tick(); s = ecount;
    for (int k = 0; k < 4; k++) hv[2][k*64 +: 64] = 64'hC000_0000_0000_0000 + 64'(k);
    tick(7); st[2] = 0;
    tick(6);
    chk("w64 count", 64'(lg_n[2] - n0), 64'd8);
    chk("w64 w0 data", lg_data[2][n0], 64'hB000_0000_0000_0000);
    chk("w64 w0 addr", 64'(lg_addr[2][n0]), 64'h3);
    chk("w64 w3 data", lg_data[2][n0+3], 64'hB000_0000_0000_0003);
    chk("w64 w3 addr", 64'(lg_addr[2][n0+3]), 64'h6);
    chk("w64 w3 cycle", 64'(lg_cyc[2][n0+3] - s + 1), 64'd4);
    chk("w64 gap", 64'(lg_cyc[2][n0+4] - lg_cyc[2][n0+3]), 64'd3);
    chk("w64 2nd w0 data", lg_data[2][n0+4], 64'hC000_0000_0000_0000);
    chk("w64 2nd w0 addr", 64'(lg_addr[2][n0+4]), 64'h3);
    chk("w64 2nd w3 data", lg_data[2][n0+7], 64'hC000_0000_0000_0003);
    chk("w64 done count", 64'(dn_n[2] - q0), 64'd2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
